// File: rtl/ddr3_frame_reader.sv
// Frame fetch engine: walks a ring of DDR3 frame buffers with Avalon-MM burst reads,
// limits in-flight beats with a credit counter and optionally re-reads the last frame.
module ddr3_frame_reader #(
  parameter int ADDR_WIDTH      = 26,
  parameter int NUM_BUFFERS     = 4,
  parameter int BUF_IDX_WIDTH   = 2,
  parameter int FRAME_BEATS     = 327680,
  parameter int BEAT_CNT_WIDTH  = 20,
  parameter int BURST_LEN       = 8,
  parameter int SIZE_WIDTH      = 7,
  parameter int MAX_OUTSTANDING = 64,
  parameter int REPEAT_LAST     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_BUFFERS*ADDR_WIDTH-1:0] buffer_base,
  input  logic [NUM_BUFFERS-1:0]            buffer_ready_set,
  output logic [NUM_BUFFERS-1:0]            buffer_ready,
  output logic [NUM_BUFFERS-1:0]            buffer_released,
  input  logic                              fifo_almost_full,
  input  logic                              avl_ready,
  output logic                              avl_burstbegin,
  output logic [SIZE_WIDTH-1:0]             avl_size,
  output logic                              avl_read_req,
  output logic [ADDR_WIDTH-1:0]             avl_addr,
  input  logic                              avl_read_data_valid,
  output logic [BUF_IDX_WIDTH-1:0]          cur_buffer,
  output logic                              frame_start,
  output logic                              busy
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + BURST_LEN + 1);
  localparam logic [OUT_W-1:0]          BURST_OUT   = OUT_W'(BURST_LEN);
  localparam logic [OUT_W-1:0]          MAX_OUT     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [BEAT_CNT_WIDTH-1:0] BURST_BEATS = BEAT_CNT_WIDTH'(BURST_LEN);
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT   = BEAT_CNT_WIDTH'(FRAME_BEATS - BURST_LEN);
  localparam logic [BUF_IDX_WIDTH-1:0]  LAST_IDX    = BUF_IDX_WIDTH'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, ABORT} state_t;

  state_t                    state_q;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;
  logic [OUT_W-1:0]          out_q, out_d;
  logic [NUM_BUFFERS-1:0]    ready_q, ready_d;
  logic [NUM_BUFFERS-1:0]    released_q, released_d;
  logic [BUF_IDX_WIDTH-1:0]  cur_q, next_idx;
  logic [ADDR_WIDTH-1:0]     addr_q, base_sel;
  logic                      read_req_q, burstbegin_q, frame_start_q, busy_q;
  logic                      accept, credit_ok, drain_done, next_ready, release_now;

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    accept      = read_req_q && avl_ready;
    base_sel    = buffer_base[cur_q*ADDR_WIDTH +: ADDR_WIDTH];
    next_idx    = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;
    next_ready  = ready_q[next_idx];
    credit_ok   = !fifo_almost_full && (out_q + BURST_OUT <= MAX_OUT);
    drain_done  = (state_q == DRAIN) && (out_q == '0);
    release_now = drain_done && (next_ready || (REPEAT_LAST == 0));

    // Valids arriving with nothing in flight are stray and must not wrap the counter.
    out_d = out_q;
    if (accept) out_d = out_d + BURST_OUT;
    if (avl_read_data_valid && (out_d != '0)) out_d = out_d - 1'b1;

    released_d        = '0;
    released_d[cur_q] = release_now;
    // A producer set in the same cycle as the release keeps the flag up.
    ready_d = (ready_q & ~released_d) | buffer_ready_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      out_q         <= '0;
      ready_q       <= '0;
      released_q    <= '0;
      cur_q         <= '0;
      addr_q        <= '0;
      read_req_q    <= 1'b0;
      burstbegin_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      out_q         <= out_d;
      ready_q       <= ready_d;
      released_q    <= released_d;
      burstbegin_q  <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && ready_q[cur_q]) begin
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (read_req_q) begin
            if (avl_ready) begin
              read_req_q    <= 1'b0;
              beat_cnt_q    <= beat_cnt_q + BURST_BEATS;
              frame_start_q <= (beat_cnt_q == '0);
              if (beat_cnt_q == LAST_BEAT) state_q <= DRAIN;
              else if (!enable)            state_q <= ABORT;
            end
          end else if (!enable) begin
            state_q <= ABORT;
          end else if (credit_ok) begin
            read_req_q   <= 1'b1;
            burstbegin_q <= 1'b1;
            addr_q       <= base_sel + ADDR_WIDTH'(beat_cnt_q);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            beat_cnt_q <= '0;
            if (next_ready || (REPEAT_LAST == 0)) cur_q <= next_idx;
            if (next_ready || (REPEAT_LAST != 0)) begin
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ABORT: begin
          // Aborted frames keep their buffer; the frame restarts from offset 0.
          if (out_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buffer_ready    = ready_q;
  assign buffer_released = released_q;
  assign avl_burstbegin  = burstbegin_q;
  assign avl_size        = SIZE_WIDTH'(BURST_LEN);
  assign avl_read_req    = read_req_q;
  assign avl_addr        = addr_q;
  assign cur_buffer      = cur_q;
  assign frame_start     = frame_start_q;
  assign busy            = busy_q;

endmodule

// File: doc/ddr3_frame_reader.md
Name: ddr3_frame_reader

Overview:
- Parametrised successor to the double-buffered DDR3 frame fetch engine.
- Reads whole frames from a ring of NUM_BUFFERS DDR3 frame buffers using Avalon-MM burst reads, and feeds the downstream pixel FIFO.
- Adds configurable burst length, credit-based outstanding-read limiting and a repeat-last-frame mode.
- Sits between the register block (buffer bases, ready/release flags) and the DDR3 controller's Avalon port. Single clock domain.

Parameters:
- ADDR_WIDTH, 26, Avalon word-address width.
- NUM_BUFFERS, 4, frame buffers in the ring. Range 2..16.
- BUF_IDX_WIDTH, 2, width of buffer index. Equals clog2(NUM_BUFFERS).
- FRAME_BEATS, 327680, 128-bit beats per frame (1280x1024x32bpp). Must be a multiple of BURST_LEN.
- BEAT_CNT_WIDTH, 20, width of the frame beat counter.
- BURST_LEN, 8, beats per burst. Power of two, 1..64.
- SIZE_WIDTH, 7, width of avl_size.
- MAX_OUTSTANDING, 64, maximum requested-but-unreturned beats. Must be >= BURST_LEN.
- REPEAT_LAST, 1, behaviour when the next buffer is not ready. 1 = re-read the current buffer. 0 = release it and idle.

Ports:
- clk  in  1  block clock (DDR3 user clock).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  fetch enable.
- buffer_base  in  NUM_BUFFERS*ADDR_WIDTH  word base address per buffer. Buffer i occupies slice i.
- buffer_ready_set  in  NUM_BUFFERS  one-cycle pulse per buffer: producer marks the buffer full.
- buffer_ready  out  NUM_BUFFERS  per-buffer full flags.
- buffer_released  out  NUM_BUFFERS  one-cycle pulse when a buffer is handed back to the producer.
- fifo_almost_full  in  1  downstream FIFO back-pressure.
- avl_ready  in  1  controller ready.
- avl_burstbegin  out  1  first cycle of a burst request.
- avl_size  out  SIZE_WIDTH  burst size.
- avl_read_req  out  1  read request.
- avl_addr  out  ADDR_WIDTH  burst word address.
- avl_read_data_valid  in  1  one returned beat.
- cur_buffer  out  BUF_IDX_WIDTH  buffer being read.
- frame_start  out  1  pulse when a frame's first burst is accepted.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset values: avl_read_req=0, avl_burstbegin=0, avl_addr=0, avl_size=BURST_LEN, buffer_ready=0, buffer_released=0, cur_buffer=0, frame_start=0, busy=0. Beat counter and outstanding counter are 0. State is IDLE.
- All outputs are registered. avl_size is constant BURST_LEN.
- States:
  - IDLE -> REQ when enable && buffer_ready[cur_buffer]. The beat counter is cleared on this transition.
  - REQ: present a burst when enable && !fifo_almost_full && outstanding+BURST_LEN <= MAX_OUTSTANDING.
  - Address of each burst is buffer_base[cur_buffer] + beat_cnt, with modulo-2^ADDR_WIDTH wrap.
  - Once presented, avl_read_req and avl_addr are held stable until avl_ready. avl_burstbegin is high only on the first presentation cycle.
  - On acceptance (read_req && ready): beat_cnt += BURST_LEN and outstanding += BURST_LEN. The next request may be presented on the following cycle.
  - Accepting the last burst (beat_cnt reaches FRAME_BEATS) -> DRAIN.
  - DRAIN: wait until outstanding == 0, then evaluate n = (cur_buffer+1) mod NUM_BUFFERS:
    - buffer_ready[n]: pulse buffer_released[cur_buffer], clear its flag, cur_buffer <= n, -> REQ with beat_cnt=0.
    - Else if REPEAT_LAST=1: no release, -> REQ on the same buffer.
    - Else: release cur_buffer, cur_buffer <= n, -> IDLE.
- Outstanding counter:
  - Decrements by 1 per avl_read_data_valid. Acceptance and valid in the same cycle apply both (net +BURST_LEN-1).
  - Saturates at 0; stray valids after reset are ignored.
- Ready flags: buffer_ready_set[i] sets flag i. If a set and a release of the same buffer occur in the same cycle, set wins and the release pulse is still emitted.
- enable falls in REQ:
  - A request already presented completes its handshake; no new requests are presented.
  - Go to DRAIN-abort: wait for outstanding == 0, then IDLE with no release.
  - On re-enable the frame restarts at offset 0 of the same buffer.
- fifo_almost_full only gates new presentations. It never withdraws a presented request.
- frame_start pulses 1 cycle on acceptance of the burst at beat_cnt == 0.
- Asynchronous reset mid-operation forces reset values immediately. No release pulse is emitted.

Test Plan:
1. FRAME_BEATS=32, BURST_LEN=8, MAX_OUTSTANDING=16, base0=0x1000, base1=0x2000. Set ready[0], ready[1], enable, always-ready controller, 8-cycle read latency -> bursts at 0x1000, 0x1008, 0x1010, 0x1018, size 8, one frame_start. After 32 valids: buffer_released[0] one pulse, then bursts from 0x2000.
2. Same setup, withhold all valids -> exactly 2 bursts accepted, then read_req stays low. Each 8 returned valids release exactly one more burst.
3. avl_ready low for 5 cycles on the second burst -> read_req high for 5 cycles, addr 0x1008 stable, burstbegin high 1 cycle only.
4. REPEAT_LAST=1, only ready[0] set -> buffer 0 re-read, no release. Set ready[1] mid-frame -> switch to 0x2000 at frame end. With REPEAT_LAST=0 -> release[0], cur_buffer=1, IDLE, busy=0.
5. fifo_almost_full high -> no new read_req. Drop enable mid-frame -> outstanding drains to 0, IDLE, no release. Re-enable -> restart at 0x1000.
6. Assert reset with a request pending and 8 beats outstanding -> all outputs at reset values immediately. Subsequent valids leave outstanding at 0 and the ready flags at 0.
